// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into short-press, long-press and auto-repeat
// pulses, with all hold timing measured in prescaled ticks.
module btn_event_decoder #(
  parameter int TICK_DIV     = 27000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          btn_q;
  logic [PW-1:0] presc, presc_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic          press_nxt, long_nxt, repeat_nxt, held_nxt;
  logic          tick, press_edge;

  assign tick       = (presc == PRE_LAST);
  assign press_edge = i_btn & ~btn_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      btn_q    <= 1'b1;   // a button held through reset must be released first
      presc    <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      o_press  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_held   <= 1'b0;
    end else begin
      state    <= state_nxt;
      btn_q    <= i_btn;
      presc    <= presc_nxt;
      hold_cnt <= hold_nxt;
      rep_cnt  <= rep_nxt;
      o_press  <= press_nxt;
      o_long   <= long_nxt;
      o_repeat <= repeat_nxt;
      o_held   <= held_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    presc_nxt  = '0;
    hold_nxt   = hold_cnt;
    rep_nxt    = rep_cnt;
    press_nxt  = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (press_edge) begin
          state_nxt = SHORT;
          hold_nxt  = '0;
        end
      end

      SHORT: begin
        // release has priority over a threshold tick on the same edge
        if (!i_btn) begin
          press_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          presc_nxt = tick ? '0 : presc + PW'(1);
          if (tick) begin
            hold_nxt = hold_cnt + HW'(1);
            if (hold_cnt == HOLD_LAST) begin
              long_nxt  = 1'b1;
              rep_nxt   = '0;
              state_nxt = LONG;
            end
          end
        end
      end

      LONG: begin
        if (!i_btn) begin
          state_nxt = IDLE;
        end else begin
          // prescaler keeps its phase across SHORT->LONG so repeats stay on the tick grid
          presc_nxt = tick ? '0 : presc + PW'(1);
          if (tick && REPEAT_EN) begin
            if (rep_cnt == REP_LAST) begin
              repeat_nxt = 1'b1;
              rep_nxt    = '0;
            end else begin
              rep_nxt = rep_cnt + RW'(1);
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    held_nxt = (state_nxt == SHORT) || (state_nxt == LONG);
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed events (kind, producing edge),
// a negedge monitor pops and compares whenever a pulse appears.
module tb_btn_event_decoder;

  localparam int K_PRESS = 1, K_LONG = 2, K_REP = 3;

  logic clk = 1'b0;
  logic rst, btn;
  logic press_a, long_a, rep_a, held_a;
  logic press_b, long_b, rep_b, held_b;

  btn_event_decoder #(.TICK_DIV(4), .LONG_TICKS(5), .REPEAT_TICKS(2), .REPEAT_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_press(press_a), .o_long(long_a), .o_repeat(rep_a), .o_held(held_a)
  );

  btn_event_decoder #(.TICK_DIV(4), .LONG_TICKS(5), .REPEAT_TICKS(2), .REPEAT_EN(1'b0)) dut_norep (
    .i_clk(clk), .i_rst(rst), .i_btn(btn),
    .o_press(press_b), .o_long(long_b), .o_repeat(rep_b), .o_held(held_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int at; } ev_t;
  ev_t qa[$];
  ev_t qb[$];

  int n_vec = 0, n_err = 0;
  int held_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // repeats are only expected from the REPEAT_EN=1 instance
  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    qa.push_back(e);
    if (kind != K_REP) qb.push_back(e);
  endtask

  task automatic mon(input int which, input logic p, input logic l, input logic r);
    int k, n;
    ev_t e;
    n = int'(p) + int'(l) + int'(r);
    k = p ? K_PRESS : l ? K_LONG : r ? K_REP : 0;
    if (n != 0) begin
      check(which == 0 ? "pulse_excl_a" : "pulse_excl_b", n, 1);
      if ((which == 0 ? qa.size() : qb.size()) == 0) begin
        check(which == 0 ? "unexpected_ev_a" : "unexpected_ev_b", k, 0);
      end else begin
        e = (which == 0) ? qa.pop_front() : qb.pop_front();
        check(which == 0 ? "ev_kind_a" : "ev_kind_b", k, e.kind);
        check(which == 0 ? "ev_edge_a" : "ev_edge_b", cyc - 1, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    held_cnt += int'(held_a);
    mon(0, press_a, long_a, rep_a);
    mon(1, press_b, long_b, rep_b);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // button high for h sampled edges starting at the returned e0
  task automatic hold_btn(input int h, output int e0);
    e0  = cyc;
    btn = 1'b1;
    wait_neg(h);
    btn = 1'b0;
  endtask

  int e0, h0;

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    wait_neg(2);
    check("reset_outs_a", int'({press_a, long_a, rep_a, held_a}), 0);
    check("reset_outs_b", int'({press_b, long_b, rep_b, held_b}), 0);
    rst = 1'b0;
    wait_neg(3);

    // short press, 10 cycles
    h0 = held_cnt;
    expect_ev(K_PRESS, cyc + 10);
    hold_btn(10, e0);
    wait_neg(4);
    check("short_held_cycles", held_cnt - h0, 10);

    // long hold; release lands on the third repeat tick (E0+44) and suppresses it
    h0 = held_cnt;
    expect_ev(K_LONG, cyc + 20);
    expect_ev(K_REP,  cyc + 28);
    expect_ev(K_REP,  cyc + 36);
    hold_btn(44, e0);
    wait_neg(4);
    check("long_held_cycles", held_cnt - h0, 44);

    // release on the long-threshold edge: press only
    h0 = held_cnt;
    expect_ev(K_PRESS, cyc + 20);
    hold_btn(20, e0);
    wait_neg(4);
    check("race_held_cycles", held_cnt - h0, 20);

    // 60-cycle hold: REPEAT_EN=0 instance gives only o_long
    h0 = held_cnt;
    expect_ev(K_LONG, cyc + 20);
    expect_ev(K_REP,  cyc + 28);
    expect_ev(K_REP,  cyc + 36);
    expect_ev(K_REP,  cyc + 44);
    expect_ev(K_REP,  cyc + 52);
    hold_btn(60, e0);
    wait_neg(4);
    check("hold60_held_cycles", held_cnt - h0, 60);

    // minimum one-cycle press
    expect_ev(K_PRESS, cyc + 1);
    hold_btn(1, e0);
    wait_neg(4);

    // back-to-back: 2 high, 1 low, 2 high
    h0 = held_cnt;
    expect_ev(K_PRESS, cyc + 2);
    expect_ev(K_PRESS, cyc + 5);
    hold_btn(2, e0);
    wait_neg(1);
    hold_btn(2, e0);
    wait_neg(4);
    check("b2b_held_cycles", held_cnt - h0, 4);

    // reset at E0+30 while in LONG
    expect_ev(K_LONG, cyc + 20);
    expect_ev(K_REP,  cyc + 28);
    e0  = cyc;
    btn = 1'b1;
    wait_neg(30);
    check("held_before_rst", int'(held_a), 1);
    rst = 1'b1;
    #1;
    check("rst_async_a", int'({press_a, long_a, rep_a, held_a}), 0);
    check("rst_async_b", int'({press_b, long_b, rep_b, held_b}), 0);
    wait_neg(2);
    rst = 1'b0;
    h0  = held_cnt;
    wait_neg(10);
    check("held_after_rst", held_cnt - h0, 0);
    btn = 1'b0;
    wait_neg(3);
    h0 = held_cnt;
    expect_ev(K_PRESS, cyc + 3);
    hold_btn(3, e0);
    wait_neg(4);
    check("post_rst_held_cycles", held_cnt - h0, 3);

    check("missing_ev_a", qa.size(), 0);
    check("missing_ev_b", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
